signed_bcd_converter: RTL and testbench



---
 rtl/signed_bcd_converter.sv | 142 ++++++++++++++
 tb/tb_signed_bcd_converter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/signed_bcd_converter.sv
// Sequential signed binary-to-BCD converter (iterative double-dabble, WIDTH cycles per sample).
// Build option: SIGNED_BCD_LEADING_BLANK_EN blanks leading zero digits with 4'hF.
module signed_bcd_converter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      din,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned BcdW = 4 * DIGITS;

    typedef enum logic [0:0] {StIdle, StConv} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic              sgn_q, sgn_d;
    logic [BcdW-1:0]   scratch_q, scratch_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              neg_q, neg_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic              ovf_q, ovf_d;

    logic [BcdW-1:0]   adj;
    logic [BcdW-1:0]   shift_scr;
    logic              shift_carry;
    logic [BcdW-1:0]   out_bcd;
`ifdef SIGNED_BCD_LEADING_BLANK_EN
    logic              lead;
`endif

    // Datapath for one double-dabble step and the value presented on the final step.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        shift_scr   = {adj[BcdW-2:0], mag_q[WIDTH-1]};
        shift_carry = carry_q | adj[BcdW-1];

        out_bcd = shift_scr;
`ifdef SIGNED_BCD_LEADING_BLANK_EN
        lead = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (lead && (out_bcd[4*i +: 4] == 4'd0)) begin
                out_bcd[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
`endif
        if (shift_carry) begin
            out_bcd = '1;
        end
    end

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        sgn_d     = sgn_q;
        scratch_d = scratch_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        neg_d     = neg_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    // Two's-complement negate; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
                    mag_d     = din[WIDTH-1] ? WIDTH'(~din + 1'b1) : din;
                    sgn_d     = din[WIDTH-1];
                    scratch_d = '0;
                    carry_d   = 1'b0;
                    cnt_d     = CntW'(WIDTH);
                    state_d   = StConv;
                end
            end
            StConv: begin
                scratch_d = shift_scr;
                carry_d   = shift_carry;
                mag_d     = mag_q << 1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    bcd_d   = out_bcd;
                    neg_d   = sgn_q;
                    ovf_d   = shift_carry;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mag_q     <= '0;
            sgn_q     <= 1'b0;
            scratch_q <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            neg_q     <= 1'b0;
            bcd_q     <= '1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            sgn_q     <= sgn_d;
            scratch_q <= scratch_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            neg_q     <= neg_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy     = (state_q == StConv);
    assign done     = done_q;
    assign neg      = neg_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Randomized bench for signed_bcd_converter against a decimal-arithmetic reference model.
// Also drives a DIGITS=2 instance to exercise overflow.
module tb_signed_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [7:0]  din, din2;
    logic        busy, done, neg, overflow;
    logic [11:0] bcd;
    logic        busy2, done2, neg2, ovf2;
    logic [7:0]  bcd2;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    signed_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .busy(busy), .done(done),
        .neg(neg), .bcd(bcd), .overflow(overflow)
    );

    signed_bcd_converter #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .din(din2), .busy(busy2), .done(done2),
        .neg(neg2), .bcd(bcd2), .overflow(ovf2)
    );

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal digits of |d| in nd nibbles; all 4'hF when it does not fit.
    function automatic logic [11:0] model(input logic [7:0] d, input int nd, output logic ovf);
        int v, lim;
        logic [11:0] r;
`ifdef SIGNED_BCD_LEADING_BLANK_EN
        bit lead;
`endif
        v = int'($signed(d));
        if (v < 0) v = -v;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        ovf = (v >= lim);
        r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = ovf ? 4'hF : 4'(v % 10);
            v = v / 10;
        end
`ifdef SIGNED_BCD_LEADING_BLANK_EN
        if (!ovf) begin
            lead = 1'b1;
            for (int i = nd - 1; i >= 1; i--) begin
                if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
                else lead = 1'b0;
            end
        end
`endif
        return r;
    endfunction

    task automatic accept(input logic [7:0] d);
        start = 1'b1;
        din   = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        din   = 8'($urandom);
    endtask

    // Waits for done; lat counts edges from the caller's reference point (offset k0).
    task automatic wait_done(input int k0, output int lat, output int hi);
        bit found;
        found = 1'b0;
        lat = -1;
        hi = 0;
        for (int k = 1; k <= 20; k++) begin
            if (!found) begin
                @(posedge clk);
                #1;
                if (done) begin
                    found = 1'b1;
                    lat = k0 + k;
                end else if (busy) begin
                    hi++;
                end
            end
        end
    endtask

    task automatic expect_result(input string tag, input logic [7:0] d, input int lat);
        logic [11:0] eb;
        logic        eo;
        eb = model(d, 3, eo);
        check({tag, ".lat"}, 32'(lat), 32'd8);
        check({tag, ".bcd"}, 32'(bcd), 32'(eb));
        check({tag, ".neg"}, 32'(neg), 32'(d[7]));
        check({tag, ".ovf"}, 32'(overflow), 32'(eo));
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_conv(input string tag, input logic [7:0] d, output int busy_cyc);
        int lat, hi;
        accept(d);
        check({tag, ".busy_acc"}, 32'(busy), 32'd1);
        wait_done(0, lat, hi);
        busy_cyc = hi + 1;
        expect_result(tag, d, lat);
    endtask

    task automatic run_conv2(input string tag, input logic [7:0] d);
        logic [11:0] eb;
        logic        eo;
        bit          found;
        found = 1'b0;
        start2 = 1'b1;
        din2   = d;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (!found) begin
                @(posedge clk);
                #1;
                if (done2) begin
                    found = 1'b1;
                    check({tag, ".lat"}, 32'(k), 32'd8);
                end
            end
        end
        if (!found) check({tag, ".timeout"}, 32'd0, 32'd1);
        eb = model(d, 2, eo);
        check({tag, ".bcd"}, 32'(bcd2), 32'(eb[7:0]));
        check({tag, ".ovf"}, 32'(ovf2), 32'(eo));
        check({tag, ".neg"}, 32'(neg2), 32'(d[7]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, lat, hi, dc0;
        logic [7:0] d;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; din = '0; din2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.neg", 32'(neg), 32'd0);
        check("rst.ovf", 32'(overflow), 32'd0);
        check("rst.bcd", 32'(bcd), 32'hFFF);

        run_conv("zero", 8'd0, bc);
        run_conv("pmax", 8'd127, bc);
        check("pmax.busy_cycles", 32'(bc), 32'd8);
        run_conv("nmax", 8'h80, bc);
        run_conv("m5", 8'hFB, bc);

        // start while busy is ignored; start in the done cycle is accepted
        repeat (3) @(posedge clk);
        #1;
        dc0 = done_cnt;
        accept(8'd42);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        din   = 8'd99;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(3, lat, hi);
        expect_result("hs42", 8'd42, lat);
        check("hs.done_cycle", 32'(done), 32'd1);
        run_conv("hsm99", 8'(-99), bc);
        repeat (10) @(posedge clk);
        #1;
        check("hs.done_count", 32'(done_cnt - dc0), 32'd2);

        // abort mid-conversion
        dc0 = done_cnt;
        accept(8'd77);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.bcd", 32'(bcd), 32'hFFF);
        check("abort.neg", 32'(neg), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("abort.no_done", 32'(done_cnt - dc0), 32'd0);

        run_conv2("d2_100", 8'd100);
        run_conv2("d2_m100", 8'(-100));
        run_conv2("d2_99", 8'd99);
        run_conv2("d2_m128", 8'h80);
        run_conv2("d2_7", 8'd7);

        foreach (din[i]) begin end
        for (int i = 0; i < 30; i++) begin
            d = 8'($urandom_range(0, 255));
            run_conv("rnd", d, bc);
        end
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            run_conv2("rnd2", d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
